regfile_ckpt: RTL and testbench

REGFILE_CKPT -- requirements
Module: regfile_ckpt

---
 rtl/z86_package.sv | 25 ++
 rtl/regfile_wr_merge.sv | 45 ++++
 rtl/regfile_ckpt.sv | 125 ++++++++++++
 tb/tb_regfile_ckpt.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/z86_package.sv
`default_nettype none
// ============================================================================
// Module      : z86_package
// Description : Shared z86 definitions: architectural register indices,
//               register index type and byte-lane width.
// Revision    : 1.0 - initial release
// ============================================================================
package z86_package;

    typedef logic [2:0] reg_idx_t;

    localparam reg_idx_t R_AX = 3'd0;
    localparam reg_idx_t R_CX = 3'd1;
    localparam reg_idx_t R_DX = 3'd2;
    localparam reg_idx_t R_BX = 3'd3;
    localparam reg_idx_t R_SP = 3'd4;
    localparam reg_idx_t R_BP = 3'd5;
    localparam reg_idx_t R_SI = 3'd6;
    localparam reg_idx_t R_DI = 3'd7;

    // Width of one write-enable lane
    localparam int c_BYTE_W = 8;

endpackage
`default_nettype wire

// File: rtl/regfile_wr_merge.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_merge
// Description : Combines all write ports into the next value of every
//               register plus a per-register mask of written byte lanes.
//               Later (higher-index) ports override earlier ones per lane.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_merge
    import z86_package::*;
#(
    parameter int NREGS = 8,
    parameter int DW    = 16,
    parameter int NWR   = 2,
    parameter int AW    = 3,
    parameter int NB    = 2
) (
    input  logic [NREGS*DW-1:0] i_cur,
    input  logic [NWR*NB-1:0]   i_we,
    input  logic [NWR*AW-1:0]   i_waddr,
    input  logic [NWR*DW-1:0]   i_wdata,
    output logic [NREGS*DW-1:0] o_nxt,
    output logic [NREGS*NB-1:0] o_lane_mask
);

    // Ascending port loop: the last matching port writes the lane, so the
    // highest port index wins on a same-register same-lane conflict.
    always_comb begin
        o_nxt       = i_cur;
        o_lane_mask = '0;
        for (int r = 0; r < NREGS; r++) begin
            for (int p = 0; p < NWR; p++) begin
                for (int b = 0; b < NB; b++) begin
                    if (i_we[p*NB + b] && (i_waddr[p*AW +: AW] == AW'(r))) begin
                        o_nxt[(r*NB + b)*c_BYTE_W +: c_BYTE_W] =
                            i_wdata[(p*NB + b)*c_BYTE_W +: c_BYTE_W];
                        o_lane_mask[r*NB + b] = 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_ckpt.sv
`default_nettype none
// ============================================================================
// Module      : regfile_ckpt
// Description : Multi-port z86 register file with byte-lane writes, a
//               pending-write scoreboard and a single checkpoint snapshot
//               that can be saved and rolled back.
//               Build option REGFILE_FWD_EN: forward same-cycle writes to
//               the read ports (per byte lane); otherwise reads return the
//               stored value only.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_ckpt
    import z86_package::*;
#(
    parameter int NREGS = 8,
    parameter int DW    = 16,
    parameter int NRD   = 4,
    parameter int NWR   = 2,
    // Derived widths; leave at their defaults
    parameter int AW    = $clog2(NREGS),
    parameter int NB    = DW / c_BYTE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*DW-1:0]   rdata,
    input  logic [NWR*NB-1:0]   we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*DW-1:0]   wdata,
    input  logic                busy_set,
    input  logic [AW-1:0]       busy_addr,
    output logic [NREGS-1:0]    busy,
    input  logic                ckpt_save,
    input  logic                ckpt_restore,
    output logic                ckpt_valid
);

    logic [NREGS*DW-1:0] r_regs;
    logic [NREGS*DW-1:0] r_snap;
    logic [NREGS-1:0]    r_busy;
    logic                r_valid;

    logic [NREGS*DW-1:0] w_nxt;
    logic [NREGS*NB-1:0] w_lane_mask;
    logic [NREGS-1:0]    w_busy_nxt;
    logic [NREGS*DW-1:0] w_rd_src;
    logic                w_restore;

    // A restore only takes effect when a snapshot is actually held
    assign w_restore = ckpt_restore & r_valid;

    regfile_wr_merge #(
        .NREGS (NREGS),
        .DW    (DW),
        .NWR   (NWR),
        .AW    (AW),
        .NB    (NB)
    ) u_wr_merge (
        .i_cur       (r_regs),
        .i_we        (we),
        .i_waddr     (waddr),
        .i_wdata     (wdata),
        .o_nxt       (w_nxt),
        .o_lane_mask (w_lane_mask)
    );

    // Scoreboard update: any written lane clears, a new issue sets (set wins)
    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 0; r < NREGS; r++) begin
            if (|w_lane_mask[r*NB +: NB]) begin
                w_busy_nxt[r] = 1'b0;
            end
            if (busy_set && (busy_addr == AW'(r))) begin
                w_busy_nxt[r] = 1'b1;
            end
        end
    end

`ifdef REGFILE_FWD_EN
    // Merged next values already carry per-lane forwarding; fall back to the
    // stored array whenever this cycle's writes will not land.
    assign w_rd_src = (reset || w_restore) ? r_regs : w_nxt;
`else
    assign w_rd_src = r_regs;
`endif

    // Read ports: zero-latency mux; out-of-range addresses read zero
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NRD; i++) begin
            for (int r = 0; r < NREGS; r++) begin
                if (raddr[i*AW +: AW] == AW'(r)) begin
                    rdata[i*DW +: DW] = w_rd_src[r*DW +: DW];
                end
            end
        end
    end

    // Architectural state, scoreboard and checkpoint; reset overrides all,
    // an effective restore overrides writes, busy issue and save.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_regs  <= '0;
            r_snap  <= '0;
            r_busy  <= '0;
            r_valid <= 1'b0;
        end else if (w_restore) begin
            r_regs  <= r_snap;
            r_busy  <= '0;
        end else begin
            r_regs  <= w_nxt;
            r_busy  <= w_busy_nxt;
            if (ckpt_save) begin
                r_snap  <= w_nxt;
                r_valid <= 1'b1;
            end
        end
    end

    assign busy       = r_busy;
    assign ckpt_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_regfile_ckpt.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_ckpt
// Description : Directed self-checking bench for regfile_ckpt (default
//               parameters: 8 x 16-bit, 4 read ports, 2 write ports).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_ckpt;
    import z86_package::*;

    localparam int c_AW  = 3;
    localparam int c_DW  = 16;
    localparam int c_NRD = 4;
    localparam int c_NWR = 2;
    localparam int c_NB  = 2;

    logic                   clk;
    logic                   reset;
    logic [c_NRD*c_AW-1:0]  raddr;
    logic [c_NRD*c_DW-1:0]  rdata;
    logic [c_NWR*c_NB-1:0]  we;
    logic [c_NWR*c_AW-1:0]  waddr;
    logic [c_NWR*c_DW-1:0]  wdata;
    logic                   busy_set;
    logic [c_AW-1:0]        busy_addr;
    logic [7:0]             busy;
    logic                   ckpt_save;
    logic                   ckpt_restore;
    logic                   ckpt_valid;

    int n_pass;
    int n_total;

    regfile_ckpt dut (
        .clk          (clk),
        .reset        (reset),
        .raddr        (raddr),
        .rdata        (rdata),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .busy_set     (busy_set),
        .busy_addr    (busy_addr),
        .busy         (busy),
        .ckpt_save    (ckpt_save),
        .ckpt_restore (ckpt_restore),
        .ckpt_valid   (ckpt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic clear_in();
        reset        = 1'b0;
        we           = '0;
        waddr        = '0;
        wdata        = '0;
        busy_set     = 1'b0;
        busy_addr    = '0;
        ckpt_save    = 1'b0;
        ckpt_restore = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic wr(input int p, input reg_idx_t a, input logic [1:0] lanes,
                      input logic [15:0] d);
        we[p*c_NB +: c_NB]    = lanes;
        waddr[p*c_AW +: c_AW] = a;
        wdata[p*c_DW +: c_DW] = d;
    endtask

    task automatic rd_chk(input string tag, input reg_idx_t a, input logic [15:0] exp);
        raddr[c_AW-1:0] = a;
        #1;
        chk(tag, {16'h0, rdata[c_DW-1:0]}, {16'h0, exp});
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        raddr   = '0;
        clear_in();

        // Reset with traffic on every other input: reset must dominate
        reset = 1'b1;
        wr(0, R_AX, 2'b11, 16'hFFFF);
        busy_set = 1'b1; busy_addr = R_SP;
        ckpt_save = 1'b1;
        tick();
        raddr = {R_DI, R_BX, R_CX, R_AX};
        #1;
        chk("reset_rdata", {rdata[63:32] | rdata[31:0]}, 32'h0);
        chk("reset_busy", {24'h0, busy}, 32'h0);
        chk("reset_valid", {31'h0, ckpt_valid}, 32'h0);

        // Full-word write to BX
        wr(0, R_BX, 2'b11, 16'h1234);
        tick();
        rd_chk("bx_write", R_BX, 16'h1234);

        // Two ports on AX, port1 low lane overrides port0
        wr(0, R_AX, 2'b11, 16'hAAAA);
        wr(1, R_AX, 2'b01, 16'h5555);
        tick();
        rd_chk("ax_merge", R_AX, 16'hAA55);

        // Scoreboard: issue, then completion, then both in one cycle
        busy_set = 1'b1; busy_addr = R_CX;
        tick();
        chk("busy_set_cx", {24'h0, busy}, 32'h0000_0002);
        wr(1, R_CX, 2'b10, 16'h7700);
        tick();
        chk("busy_clr_cx", {24'h0, busy}, 32'h0);
        rd_chk("cx_hi_lane", R_CX, 16'h7700);
        busy_set = 1'b1; busy_addr = R_CX;
        wr(0, R_CX, 2'b11, 16'h0102);
        tick();
        chk("busy_set_wins", {24'h0, busy}, 32'h0000_0002);

        // Save in the same cycle as a DX write: snapshot holds post-write
        wr(0, R_DX, 2'b11, 16'h0001);
        ckpt_save = 1'b1;
        tick();
        chk("save_valid", {31'h0, ckpt_valid}, 32'h1);
        wr(0, R_DX, 2'b11, 16'h0002);
        tick();
        rd_chk("dx_after_save", R_DX, 16'h0002);

        // Restore discards same-cycle write and busy issue, clears busy
        ckpt_restore = 1'b1;
        wr(0, R_SI, 2'b11, 16'h3333);
        busy_set = 1'b1; busy_addr = R_BP;
        tick();
        rd_chk("restore_dx", R_DX, 16'h0001);
        rd_chk("restore_si", R_SI, 16'h0000);
        rd_chk("restore_ax", R_AX, 16'hAA55);
        chk("restore_busy", {24'h0, busy}, 32'h0);
        chk("restore_valid", {31'h0, ckpt_valid}, 32'h1);

        // Repeated restore returns the same snapshot
        wr(1, R_DX, 2'b11, 16'h0009);
        tick();
        ckpt_restore = 1'b1;
        tick();
        rd_chk("restore_again", R_DX, 16'h0001);

        // Save together with restore: restore only, snapshot untouched
        wr(0, R_DX, 2'b11, 16'h0005);
        tick();
        ckpt_save = 1'b1; ckpt_restore = 1'b1;
        tick();
        rd_chk("save_restore_dx", R_DX, 16'h0001);
        ckpt_restore = 1'b1;
        tick();
        rd_chk("snap_unchanged", R_DX, 16'h0001);

        // Same-cycle read of a register being written
        wr(0, R_DI, 2'b11, 16'hBEEF);
        raddr[2*c_AW +: c_AW] = R_DI;
        #1;
`ifdef REGFILE_FWD_EN
        chk("fwd_di", {16'h0, rdata[2*c_DW +: c_DW]}, 32'h0000_BEEF);
`else
        chk("nofwd_di", {16'h0, rdata[2*c_DW +: c_DW]}, 32'h0);
`endif
        tick();
        rd_chk("di_written", R_DI, 16'hBEEF);

        // Reset during a restore with valid snapshot
        reset = 1'b1; ckpt_restore = 1'b1;
        wr(0, R_SI, 2'b11, 16'h4444);
        tick();
        raddr = {R_DI, R_DX, R_CX, R_AX};
        #1;
        chk("reset_mid_rdata", {rdata[63:32] | rdata[31:0]}, 32'h0);
        chk("reset_mid_valid", {31'h0, ckpt_valid}, 32'h0);

        // Restore with no snapshot is ignored; write and busy proceed
        ckpt_restore = 1'b1;
        wr(0, R_SI, 2'b11, 16'h00FF);
        busy_set = 1'b1; busy_addr = R_SI;
        tick();
        rd_chk("norestore_si", R_SI, 16'h00FF);
        chk("norestore_busy", {24'h0, busy}, 32'h0000_0040);
        chk("norestore_valid", {31'h0, ckpt_valid}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
